// File: rtl/expu_row_accumulator.sv
// Row-sum (softmax denominator) accumulator for exp-unit results, FP16ALT (bfloat16) elements.
// Optional macro EXPU_ACC_ROUND_EN selects round-to-nearest-even on the output conversion.
module expu_row_accumulator #(
    parameter int EXPONENT_BITS = 8,   // FP16ALT exponent field
    parameter int MANTISSA_BITS = 7,   // FP16ALT mantissa field
    parameter int ACC_FRAC_BITS = 16,
    parameter int ACC_INT_BITS  = 8,
    parameter int CNT_WIDTH     = 16,
    localparam int WIDTH     = 1 + EXPONENT_BITS + MANTISSA_BITS,
    localparam int BIAS      = 2 ** (EXPONENT_BITS - 1) - 1,
    localparam int ACC_WIDTH = ACC_INT_BITS + ACC_FRAC_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     op_i,
    input  logic                 last_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     sum_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 sat_o
);

    // Exponent at which the mantissa LSB lands on the accumulator LSB.
    localparam int SH_OFF = BIAS - ACC_FRAC_BITS + MANTISSA_BITS;
    // Smallest exponent whose value reaches 2^ACC_INT_BITS.
    localparam int SAT_E  = BIAS + ACC_INT_BITS;

    typedef enum logic {ACCUM, DONE} state_t;

    state_t                 state, state_next;
    logic [ACC_WIDTH-1:0]   acc, acc_next;
    logic [CNT_WIDTH-1:0]   count, count_next;
    logic                   sat, sat_next;

    logic [EXPONENT_BITS-1:0] in_exp;
    logic [MANTISSA_BITS:0]   in_mant;
    logic [ACC_WIDTH-1:0]     contrib;
    logic                     force_sat;
    logic [ACC_WIDTH:0]       acc_sum;
    logic                     unused_sign;
    int                       ev;

    assign in_exp      = op_i[WIDTH-2 -: EXPONENT_BITS];
    assign in_mant     = {1'b1, op_i[MANTISSA_BITS-1:0]};
    assign unused_sign = op_i[WIDTH-1];  // magnitude only

    always_comb begin
        contrib   = '0;
        force_sat = 1'b0;
        ev        = int'(in_exp);
        if (in_exp == '1) begin
            force_sat = 1'b1;
        end else if (in_exp != '0) begin
            if (ev >= SAT_E)
                force_sat = 1'b1;
            else if (ev >= SH_OFF)
                contrib = ACC_WIDTH'(in_mant) << (ev - SH_OFF);
            else
                contrib = ACC_WIDTH'(in_mant >> (SH_OFF - ev));
        end
    end

    assign acc_sum = {1'b0, acc} + {1'b0, contrib};

    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        sat_next   = sat;
        case (state)
            ACCUM: if (valid_i) begin
                count_next = (count == '1) ? count : count + CNT_WIDTH'(1);
                if (sat || force_sat || acc_sum[ACC_WIDTH]) begin
                    acc_next = '1;
                    sat_next = 1'b1;
                end else begin
                    acc_next = acc_sum[ACC_WIDTH-1:0];
                end
                if (last_i) state_next = DONE;
            end
            DONE: if (ready_i) begin
                state_next = ACCUM;
                acc_next   = '0;
                count_next = '0;
                sat_next   = 1'b0;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            sat   <= sat_next;
        end
    end

    // Fixed-point to FP: normalise so the leading one drops off the top of norm.
    int                       lead;
    logic [ACC_WIDTH-2:0]     norm;
    logic [EXPONENT_BITS-1:0] out_exp;
    logic [MANTISSA_BITS-1:0] out_mant;
    logic [WIDTH-1:0]         fp_sum;

    always_comb begin
        lead = 0;
        for (int i = 0; i < ACC_WIDTH; i++)
            if (acc[i]) lead = i;
        norm = (ACC_WIDTH-1)'(acc << (ACC_WIDTH - 1 - lead));
    end

`ifdef EXPU_ACC_ROUND_EN
    logic                 guard, sticky, round_up;
    logic [MANTISSA_BITS:0] mant_rnd;

    assign guard    = norm[ACC_WIDTH-2-MANTISSA_BITS];
    assign sticky   = |norm[ACC_WIDTH-3-MANTISSA_BITS:0];
    assign round_up = guard && (sticky || norm[ACC_WIDTH-1-MANTISSA_BITS]);
    assign mant_rnd = {1'b0, norm[ACC_WIDTH-2 -: MANTISSA_BITS]} + (MANTISSA_BITS+1)'(round_up);

    always_comb begin
        out_exp  = EXPONENT_BITS'(lead - ACC_FRAC_BITS + BIAS);
        out_mant = mant_rnd[MANTISSA_BITS-1:0];
        if (mant_rnd[MANTISSA_BITS]) out_exp = out_exp + EXPONENT_BITS'(1);
    end
`else
    logic unused_low;
    assign unused_low = ^norm[ACC_WIDTH-2-MANTISSA_BITS:0];

    always_comb begin
        out_exp  = EXPONENT_BITS'(lead - ACC_FRAC_BITS + BIAS);
        out_mant = norm[ACC_WIDTH-2 -: MANTISSA_BITS];
    end
`endif

    assign fp_sum  = (acc == '0) ? '0 : {1'b0, out_exp, out_mant};

    assign ready_o = (state == ACCUM);
    assign valid_o = (state == DONE);
    assign sum_o   = (state == DONE) ? fp_sum : '0;
    assign count_o = count;
    assign sat_o   = sat;

endmodule

// File: tb/tb_expu_row_accumulator.sv
// Directed self-checking bench for expu_row_accumulator (bfloat16 elements).
module tb_expu_row_accumulator;

    logic        clk_i = 1'b0;
    logic        rst_ni, clear_i, valid_i, last_i, ready_i;
    logic [15:0] op_i;
    logic        ready_o, valid_o, sat_o;
    logic [15:0] sum_o, count_o;

    int total = 0;
    int bad   = 0;

`ifdef EXPU_ACC_ROUND_EN
    localparam logic [15:0] SAT_SUM = 16'h4380;
    localparam logic [15:0] RND_SUM = 16'h3F82;
`else
    localparam logic [15:0] SAT_SUM = 16'h437F;
    localparam logic [15:0] RND_SUM = 16'h3F81;
`endif

    expu_row_accumulator dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i), .last_i(last_i),
        .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o),
        .count_o(count_o), .sat_o(sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic beat(input logic [15:0] op, input logic last);
        valid_i = 1'b1; op_i = op; last_i = last;
        @(posedge clk_i); #1;
        valid_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic handoff();
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        total++; if ({sum_o, count_o, sat_o} !== 33'd0) begin bad++; $display("FAIL reset_outs sum=%h cnt=%0d sat=%b exp=0", sum_o, count_o, sat_o); end
        rst_ni = 1'b1;
        beat(16'h3F80, 1'b0);
        beat(16'h3F80, 1'b0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        total++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || count_o !== 16'd0) begin bad++; $display("FAIL midrow_reset ready=%b valid=%b cnt=%0d exp 1/0/0", ready_o, valid_o, count_o); end
        beat(16'h3F00, 1'b1);
        total++; if (valid_o !== 1'b1 || sum_o !== 16'h3F00 || count_o !== 16'd1) begin bad++; $display("FAIL post_reset_row valid=%b sum=%h cnt=%0d exp 1/3f00/1", valid_o, sum_o, count_o); end
        handoff();
        total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL handoff1 valid=%b ready=%b exp 0/1", valid_o, ready_o); end
    endtask

    task automatic test_back_to_back();
        beat(16'h3F80, 1'b0);
        beat(16'h3F00, 1'b0);
        beat(16'h3E80, 1'b1);
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL b2b_latency valid=%b exp=1", valid_o); end
        total++; if (sum_o !== 16'h3FE0 || count_o !== 16'd3 || sat_o !== 1'b0) begin bad++; $display("FAIL b2b_sum sum=%h cnt=%0d sat=%b exp 3fe0/3/0", sum_o, count_o, sat_o); end
        handoff();
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) beat(16'h3F80, i == 3);
        valid_i = 1'b1; op_i = 16'h3F80; last_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (valid_o !== 1'b1 || ready_o !== 1'b0 || sum_o !== 16'h4080 || count_o !== 16'd4) begin
                bad++; $display("FAIL hold_cyc%0d valid=%b ready=%b sum=%h cnt=%0d exp 1/0/4080/4", i, valid_o, ready_o, sum_o, count_o);
            end
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0; last_i = 1'b0;
        handoff();
        beat(16'h3F00, 1'b1);
        total++; if (sum_o !== 16'h3F00 || count_o !== 16'd1) begin bad++; $display("FAIL hold_next_row sum=%h cnt=%0d exp 3f00/1", sum_o, count_o); end
        handoff();
    endtask

    task automatic test_small_terms();
        beat(16'h3F80, 1'b0);
        beat(16'h3580, 1'b1);
        total++; if (sum_o !== 16'h3F80 || count_o !== 16'd2) begin bad++; $display("FAIL tiny_term sum=%h cnt=%0d exp 3f80/2", sum_o, count_o); end
        handoff();
        beat(16'h3F80, 1'b0);
        beat(16'h0001, 1'b1);
        total++; if (sum_o !== 16'h3F80 || count_o !== 16'd2) begin bad++; $display("FAIL denormal sum=%h cnt=%0d exp 3f80/2", sum_o, count_o); end
        handoff();
        // negative sign bit uses magnitude
        beat(16'hBF80, 1'b1);
        total++; if (sum_o !== 16'h3F80) begin bad++; $display("FAIL sign_ignored sum=%h exp 3f80", sum_o); end
        handoff();
        // 1 + 1.5*2^-7: guard set, no sticky, odd mantissa
        beat(16'h3F80, 1'b0);
        beat(16'h3C40, 1'b1);
        total++; if (sum_o !== RND_SUM) begin bad++; $display("FAIL out_round sum=%h exp %h", sum_o, RND_SUM); end
        handoff();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) beat(16'h3F80, i == 299);
        total++; if (sat_o !== 1'b1 || sum_o !== SAT_SUM || count_o !== 16'd300) begin bad++; $display("FAIL sat_300 sat=%b sum=%h cnt=%0d exp 1/%h/300", sat_o, sum_o, count_o, SAT_SUM); end
        handoff();
        total++; if (sat_o !== 1'b0 || count_o !== 16'd0) begin bad++; $display("FAIL sat_cleared sat=%b cnt=%0d exp 0/0", sat_o, count_o); end
        beat(16'h7F80, 1'b1);
        total++; if (sat_o !== 1'b1 || sum_o !== SAT_SUM) begin bad++; $display("FAIL sat_inf sat=%b sum=%h exp 1/%h", sat_o, sum_o, SAT_SUM); end
        handoff();
    endtask

    task automatic test_clear();
        beat(16'h3F80, 1'b1);
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL clear_pre valid=%b exp=1", valid_o); end
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        total++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 16'd0 || sum_o !== 16'd0) begin
            bad++; $display("FAIL clear_done valid=%b ready=%b cnt=%0d sum=%h exp 0/1/0/0", valid_o, ready_o, count_o, sum_o);
        end
        beat(16'h3E80, 1'b0);
        beat(16'h3E80, 1'b1);
        total++; if (sum_o !== 16'h3F00 || count_o !== 16'd2) begin bad++; $display("FAIL clear_next_row sum=%h cnt=%0d exp 3f00/2", sum_o, count_o); end
        handoff();
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        ready_i = 1'b0; op_i = 16'h0;
        test_reset();
        test_back_to_back();
        test_hold();
        test_small_terms();
        test_saturation();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
